feature_map_streamer: RTL and testbench

Frame-buffered raster source for the 3x3 stride-1 padding-1 convolution pipeline. The block stores one IMG_WIDHT x IMG_HEIGHT feature map written through a random-access load port. On Start it streams the map out in raster order as a Data_Out / Valid_Out pixel stream that feeds the convolution's Data_In / Valid_In. It is the transmitting end of the convolution input stream, with Busy/Done status for the layer controller.

---
 rtl/feature_map_streamer.sv | 99 +++++++++
 tb/tb_feature_map_streamer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/feature_map_streamer.sv
// feature_map_streamer: holds one feature map loaded through a random-access port and streams it in raster order.
// Define STREAMER_ROW_GAP_EN to insert one idle cycle after every row except the last.
module feature_map_streamer #(
   parameter int DATA_WIDHT = 32,
   parameter int IMG_WIDHT  = 30,
   parameter int IMG_HEIGHT = 30,
   localparam int ADDR_W    = $clog2(IMG_WIDHT*IMG_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Wr_En,
   input  logic [ADDR_W-1:0]     Wr_Addr,
   input  logic [DATA_WIDHT-1:0] Wr_Data,
   input  logic                  Start,
   output logic [DATA_WIDHT-1:0] Data_Out,
   output logic                  Valid_Out,
   output logic                  Last_Out,
   output logic                  Busy,
   output logic                  Done
);
   localparam int DEPTH = IMG_WIDHT*IMG_HEIGHT;
   localparam int CW = IMG_WIDHT > 1 ? $clog2(IMG_WIDHT) : 1;
   localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDHT-1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT-1);
`ifdef STREAMER_ROW_GAP_EN
   localparam logic GAP_EN = 1'b1;
`else
   localparam logic GAP_EN = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
   state_t                state_q, state_d;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  gap_q, gap_d;
   logic                  valid_q, valid_d;
   logic                  wr_ok;
   logic [DATA_WIDHT-1:0] mem [DEPTH];
   logic [DATA_WIDHT-1:0] rd_data_q;
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      gap_d   = gap_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: if (Start) begin
            state_d = RUN;
            col_d   = '0;
            row_d   = '0;
            addr_d  = '0;
            gap_d   = 1'b0;
         end
         RUN: if (gap_q) gap_d = 1'b0;
         else begin
            valid_d = 1'b1;
            addr_d  = addr_q + 1'b1;
            col_d   = col_q == COL_LAST ? '0 : col_q + 1'b1;
            if (col_q == COL_LAST) begin
               row_d   = row_q + 1'b1;
               state_d = row_q == ROW_LAST ? DRAIN : RUN;
               gap_d   = GAP_EN && row_q != ROW_LAST;
            end
         end
         DRAIN: state_d = FIN;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         gap_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         gap_q   <= gap_d;
         valid_q <= valid_d;
      end
   end
   // Writes only land in IDLE, so they never collide with a streaming read.
   assign wr_ok = Wr_En && state_q == IDLE && int'(Wr_Addr) < DEPTH;
   always_ff @(posedge clk) begin
      if (wr_ok) mem[Wr_Addr] <= Wr_Data;
      if (valid_d) rd_data_q <= mem[addr_q];
   end
   assign Valid_Out = valid_q;
   assign Data_Out  = valid_q ? rd_data_q : '0;
   assign Last_Out  = valid_q && state_q == DRAIN;
   assign Busy      = state_q == RUN || state_q == DRAIN;
   assign Done      = state_q == FIN;
endmodule

// File: tb/tb_feature_map_streamer.sv
// tb_feature_map_streamer: directed stimulus with a pixel scoreboard for feature_map_streamer.
module tb_feature_map_streamer;
   localparam int DW = 32, W = 4, H = 4, N = W*H, AW = $clog2(N);
   localparam int W2 = 3, H2 = 3, N2 = W2*H2, AW2 = $clog2(N2);
`ifdef STREAMER_ROW_GAP_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 0;
`endif
   localparam int SPAN = N + GAP*(H-1);
   logic          clk = 1'b0, rst = 1'b0;
   logic          wr_en = 1'b0, start = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] data_out;
   logic          valid_out, last_out, busy, done;
   logic           o_wr_en = 1'b0, o_start = 1'b0;
   logic [AW2-1:0] o_addr = '0;
   logic [DW-1:0]  o_data = '0;
   logic [DW-1:0]  o_dout;
   logic           o_valid, o_last, o_busy, o_done;
   int            vecs = 0, errs = 0;
   logic [DW-1:0] model [N];
   logic [DW:0]   sb [$];
   always #5 clk = ~clk;
   feature_map_streamer #(.DATA_WIDHT(DW), .IMG_WIDHT(W), .IMG_HEIGHT(H)) u_dut (
      .clk(clk), .rst(rst), .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data), .Start(start),
      .Data_Out(data_out), .Valid_Out(valid_out), .Last_Out(last_out), .Busy(busy), .Done(done));
   feature_map_streamer #(.DATA_WIDHT(DW), .IMG_WIDHT(W2), .IMG_HEIGHT(H2)) u_odd (
      .clk(clk), .rst(rst), .Wr_En(o_wr_en), .Wr_Addr(o_addr), .Wr_Data(o_data), .Start(o_start),
      .Data_Out(o_dout), .Valid_Out(o_valid), .Last_Out(o_last), .Busy(o_busy), .Done(o_done));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (valid_out) begin
         if (sb.size() == 0) chk("extra_pixel", 64'(valid_out), 64'd0);
         else chk("pixel", {last_out, data_out}, sb.pop_front());
      end else chk("idle_out", {last_out, data_out}, 64'd0);
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input int a, input logic [DW-1:0] d);
      wr_en = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      tick();
      wr_en = 1'b0;
      model[a] = d;
   endtask
   task automatic push_frame();
      for (int i = 0; i < N; i++) sb.push_back({i == N-1, model[i]});
   endtask
   task automatic run_frame(input bit w0, input logic [DW-1:0] d0, input int start_at, input int wr_at, input bit done_poke);
      if (w0) begin
         wr_en = 1'b1;
         wr_addr = '0;
         wr_data = d0;
         model[0] = d0;
      end
      push_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      chk("busy_after_start", {busy, valid_out, done}, 64'b100);
      for (int c = 1; c <= SPAN; c++) begin
         start = c == start_at;
         wr_en = c == wr_at;
         wr_addr = AW'(3);
         wr_data = 32'hDEAD;
         tick();
         chk("valid_slot", 64'(valid_out), 64'(((c-1) % (W+GAP)) < W));
         chk("last_busy", {last_out, busy, done}, {c == SPAN, 1'b1, 1'b0});
      end
      start = 1'b0;
      wr_en = 1'b0;
      tick();
      chk("done_cycle", {valid_out, done, busy}, 64'b010);
      start = done_poke;
      tick();
      start = 1'b0;
      chk("back_idle", {valid_out, done, busy}, 64'b000);
      repeat (2) begin
         tick();
         chk("stay_idle", {valid_out, done, busy}, 64'b000);
      end
      chk("sb_empty", 64'(sb.size()), 64'd0);
   endtask
   initial begin
      int got;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", {valid_out, last_out, busy, done, data_out}, 64'd0);
      rst = 1'b1;
      tick();
      for (int i = 0; i < N; i++) wr(i, DW'(i+1));
      run_frame(1'b0, '0, 0, 0, 1'b0);
      run_frame(1'b0, '0, 5, 0, 1'b1);
      run_frame(1'b0, '0, 0, 4, 1'b0);
      chk("model_pos3", 64'(model[3]), 64'd4);
      run_frame(1'b1, 32'hBEEF, 0, 0, 1'b0);
      push_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      rst = 1'b0;
      #2;
      chk("rst_async", {valid_out, last_out, busy, done, data_out}, 64'd0);
      sb.delete();
      repeat (2) tick();
      chk("rst_hold", {valid_out, busy, done}, 64'd0);
      rst = 1'b1;
      tick();
      for (int i = 0; i < N; i++) wr(i, DW'(i*3+7));
      run_frame(1'b0, '0, 0, 0, 1'b0);
      for (int i = 0; i < N2 + 2; i++) begin
         o_wr_en = 1'b1;
         o_addr = i < N2 ? AW2'(i) : (i == N2 ? AW2'(N2) : AW2'(15));
         o_data = i < N2 ? DW'(100+i) : 32'hBAD;
         tick();
      end
      o_wr_en = 1'b0;
      o_start = 1'b1;
      tick();
      o_start = 1'b0;
      got = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (o_valid) begin
            chk("odd_pixel", 64'(o_dout), 64'(100+got));
            got++;
         end
      end
      chk("odd_count", 64'(got), 64'(N2));
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
